// File: rtl/fsk_symbol_framer_if.sv
// Byte stream into the FSK symbol framer: valid/ready handshake with an
// end-of-frame marker.
interface fsk_symbol_framer_if;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_last, output s_valid, input s_ready);
    modport slave  (input s_data, input s_last, input s_valid, output s_ready);
endinterface

// File: rtl/fsk_symbol_framer.sv
// Buffers bytes, slices them MSB-first into k-bit symbols and drives the
// M-FSK modulator's tone index / start pair with sync, preamble and hold timing.
module fsk_symbol_framer #(
    parameter int unsigned SAMPLES_PER_SYMBOL = 64,
    parameter int unsigned SYNC_LENGTH        = 10,
    parameter int unsigned PREAMBLE_SYMS      = 4,
    parameter int unsigned FIFO_DEPTH         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fsk_symbol_framer_if.slave   s,
    input  logic [1:0]           mode,
    output logic [3:0]           tone_idx,
    output logic                 start,
    output logic                 busy,
    output logic                 sym_strobe,
    output logic                 underrun
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned SYNC_CLKS = SYNC_LENGTH + 2;
    localparam int unsigned TMAX      = (SAMPLES_PER_SYMBOL > SYNC_CLKS) ? SAMPLES_PER_SYMBOL : SYNC_CLKS;
    localparam int unsigned TW        = $clog2(TMAX);
    localparam int unsigned PW        = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
    localparam logic [TW-1:0] SYM_LAST  = TW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [TW-1:0] SYNC_LAST = TW'(SYNC_CLKS - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_SYMS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_PREAMBLE, ST_DATA, ST_TAIL} state_t;

    // Byte FIFO, entries are {last, data}
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic          full_q, full_d;
    logic          fifo_wr, fifo_rd, fifo_empty;
    logic [8:0]    fifo_head;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   buf_q, buf_d;
    logic [4:0]    bcnt_q, bcnt_d;
    logic          last_seen_q, last_seen_d;
    logic [3:0]    tone_q, tone_d;
    logic          start_q, start_d;
    logic          strobe_q, strobe_d;
    logic          underrun_q, underrun_d;

    logic [4:0]    k;
    logic [3:0]    sym_tone;
    logic          take_sym;
    logic [23:0]   ins;

    assign s.s_ready  = !full_q;
    assign fifo_wr    = s.s_valid && !full_q;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = mem_q[rd_ptr_q];

    assign k        = 5'd4 - {3'b000, mode_q};
    // Top k bits already sit at the tone MSBs; masking the rest is the s << (4-k) map.
    assign sym_tone = buf_q[15:12] & (4'hF << mode_q);

    assign tone_idx   = tone_q;
    assign start      = start_q;
    assign busy       = (state_q != ST_IDLE);
    assign sym_strobe = strobe_q;
    assign underrun   = underrun_q;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= {s.s_last, s.s_data};
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        pre_cnt_d   = pre_cnt_q;
        mode_d      = mode_q;
        buf_d       = buf_q;
        bcnt_d      = bcnt_q;
        last_seen_d = last_seen_q;
        tone_d      = tone_q;
        start_d     = 1'b0;
        strobe_d    = 1'b0;
        underrun_d  = underrun_q;
        take_sym    = 1'b0;
        fifo_rd     = 1'b0;
        ins         = '0;

        case (state_q)
            ST_IDLE: begin
                tone_d  = '0;
                timer_d = '0;
                if (!fifo_empty) begin
                    state_d     = ST_SYNC;
                    start_d     = 1'b1;
                    mode_d      = mode;
                    underrun_d  = 1'b0;
                    last_seen_d = 1'b0;
                    buf_d       = '0;
                    bcnt_d      = '0;
                end
            end
            ST_SYNC: begin
                if (timer_q == SYNC_LAST) begin
                    timer_d = '0;
                    if (PREAMBLE_SYMS == 0) begin
                        take_sym = 1'b1;
                    end else begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = '0;
                        tone_d    = '0;
                        strobe_d  = 1'b1;
                    end
                end else if (PREAMBLE_SYMS == 0 && (bcnt_q >= k || last_seen_q)) begin
                    tone_d = sym_tone;
                end
            end
            ST_PREAMBLE: begin
                if (timer_q == SYM_LAST) begin
                    timer_d = '0;
                    if (pre_cnt_q == PRE_LAST) begin
                        take_sym = 1'b1;
                    end else begin
                        pre_cnt_d = pre_cnt_q + PW'(1);
                        tone_d    = {4{pre_cnt_d[0]}};
                        strobe_d  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (timer_q == SYM_LAST) begin
                    timer_d  = '0;
                    take_sym = 1'b1;
                end
            end
            ST_TAIL: begin
                if (timer_q == SYM_LAST) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                    tone_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A symbol taken with last_seen and no more than k bits left is the
        // final (zero-padded) one, so a byte-aligned frame never adds a pad symbol.
        if (take_sym) begin
            strobe_d = 1'b1;
            state_d  = ST_DATA;
            if (bcnt_q >= k || last_seen_q) begin
                tone_d = sym_tone;
                buf_d  = buf_q << k;
                bcnt_d = (bcnt_q >= k) ? bcnt_q - k : '0;
                if (last_seen_q && bcnt_q <= k) begin
                    state_d = ST_TAIL;
                end
            end else begin
                tone_d     = '0;
                underrun_d = 1'b1;
            end
        end

        if (state_q != ST_IDLE && !last_seen_q && bcnt_q <= 5'd8 && !fifo_empty) begin
            fifo_rd = 1'b1;
            ins     = {fifo_head[7:0], 16'h0000} >> bcnt_d;
            buf_d   = buf_d | ins[23:8];
            bcnt_d  = bcnt_d + 5'd8;
            if (fifo_head[8]) begin
                last_seen_d = 1'b1;
            end
        end

        wr_ptr_d   = wr_ptr_q + AW'(fifo_wr);
        rd_ptr_d   = rd_ptr_q + AW'(fifo_rd);
        fifo_cnt_d = fifo_cnt_q + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);
        full_d     = (fifo_cnt_d == (AW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            pre_cnt_q   <= '0;
            mode_q      <= '0;
            buf_q       <= '0;
            bcnt_q      <= '0;
            last_seen_q <= 1'b0;
            tone_q      <= '0;
            start_q     <= 1'b0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pre_cnt_q   <= pre_cnt_d;
            mode_q      <= mode_d;
            buf_q       <= buf_d;
            bcnt_q      <= bcnt_d;
            last_seen_q <= last_seen_d;
            tone_q      <= tone_d;
            start_q     <= start_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            full_q      <= full_d;
        end
    end
endmodule

// File: tb/tb_fsk_symbol_framer.sv
// Directed bench for fsk_symbol_framer: frame timing, tone mapping, FIFO
// back-pressure, underrun and asynchronous reset.
module tb_fsk_symbol_framer;
    localparam int SPS      = 64;
    localparam int SYNC_LEN = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [3:0] tone_idx;
    logic       start, busy, sym_strobe, underrun;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q [$];

    fsk_symbol_framer_if bus ();

    fsk_symbol_framer #(
        .SAMPLES_PER_SYMBOL (SPS),
        .SYNC_LENGTH        (SYNC_LEN),
        .PREAMBLE_SYMS      (4),
        .FIFO_DEPTH         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s          (bus.slave),
        .mode       (mode),
        .tone_idx   (tone_idx),
        .start      (start),
        .busy       (busy),
        .sym_strobe (sym_strobe),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the byte was accepted.
    task automatic push(input logic [7:0] d, input logic l);
        int cyc;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        cyc = 0;
        while (!bus.s_ready && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 5000) check("push timeout", 0, 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input string tag);
        int sc, cyc;
        sc = 0;
        cyc = 0;
        while (sc < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (sym_strobe) sc++;
        end
        if (sc < n) check(tag, sc, n);
    endtask

    // Follows one whole frame from start pulse to idle against exp_q.
    task automatic run_frame(input string name);
        int cyc, starts;
        cyc = 0;
        while (!start && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " start"}, start, 1);
        check({name, " busy"}, busy, 1);
        starts = int'(start);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            starts += int'(start);
        end while (!sym_strobe && cyc < 100);
        check({name, " sync_len"}, cyc, SYNC_LEN + 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s tone%0d", name, i), tone_idx, exp_q[i]);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                starts += int'(start);
            end while (!sym_strobe && busy && cyc < 200);
            check($sformatf("%s hold%0d", name, i), cyc, SPS);
        end
        check({name, " end_busy"}, busy, 0);
        check({name, " end_tone"}, tone_idx, 0);
        check({name, " starts"}, starts, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] t4 [10];
        int cyc;
        t4 = '{8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hE1, 8'hD2, 8'hC3};
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        mode  = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst tone", tone_idx, 0);
        check("rst start", start, 0);
        check("rst busy", busy, 0);
        check("rst strobe", sym_strobe, 0);
        check("rst underrun", underrun, 0);
        check("rst ready", bus.s_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // 1: one byte, 16-FSK
        exp_q = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hA, 4'h5};
        fork
            push(8'hA5, 1'b1);
            run_frame("t1");
        join
        check("t1 underrun", underrun, 0);

        // 2: 8-FSK, last symbol padded
        @(negedge clk);
        mode  = 2'b01;
        exp_q = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hE, 4'hE, 4'hC, 4'h0, 4'h0, 4'h0};
        fork
            begin
                push(8'hFF, 1'b0);
                push(8'h00, 1'b1);
            end
            run_frame("t2");
        join

        // 3: 2-FSK; mode changed mid-frame must not matter
        @(negedge clk);
        mode  = 2'b11;
        exp_q = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
        fork
            begin
                push(8'h81, 1'b1);
                cyc = 0;
                while (!busy && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                mode = 2'b00;
            end
            run_frame("t3");
        join

        // 4: fill the FIFO while the bit buffer is full
        @(negedge clk);
        mode  = 2'b00;
        exp_q = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(t4[i][7:4]);
            exp_q.push_back(t4[i][3:0]);
        end
        fork
            begin
                push(8'h12, 1'b0);
                push(8'h34, 1'b0);
                wait_strobes(1, "t4 first strobe");
                for (int i = 0; i < 10; i++) begin
                    push(t4[i], (i == 9));
                    if (i == 6) check("t4 ready_after7", bus.s_ready, 1);
                    if (i == 7) check("t4 ready_after8", bus.s_ready, 0);
                end
            end
            run_frame("t4");
        join

        // 5: underrun, then the frame is completed late
        @(negedge clk);
        exp_q = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h3, 4'hC, 4'h7, 4'hE, 4'h0, 4'h0, 4'h5, 4'hA};
        fork
            begin
                int sc;
                push(8'h3C, 1'b0);
                push(8'h7E, 1'b0);
                sc = 0;
                cyc = 0;
                while (sc < 10 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (sym_strobe) begin
                        sc++;
                        if (sc == 8) check("t5 underrun_before", underrun, 0);
                        if (sc == 9) check("t5 underrun_set", underrun, 1);
                    end
                end
                push(8'h5A, 1'b1);
            end
            run_frame("t5");
        join
        check("t5 underrun_sticky", underrun, 1);

        // 6: asynchronous reset while in DATA (underrunning, FIFO holding a byte)
        @(negedge clk);
        push(8'h96, 1'b0);
        wait_strobes(5, "t6 to data");
        check("t6 underrun_cleared", underrun, 0);
        wait_strobes(2, "t6 to underrun");
        check("t6 underrun_set", underrun, 1);
        repeat (10) @(negedge clk);
        push(8'h33, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("t6 rst tone", tone_idx, 0);
        check("t6 rst start", start, 0);
        check("t6 rst busy", busy, 0);
        check("t6 rst strobe", sym_strobe, 0);
        check("t6 rst underrun", underrun, 0);
        check("t6 rst ready", bus.s_ready, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc += int'(start) + int'(busy);
        end
        check("t6 fifo_discarded", cyc, 0);
        exp_q = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h4, 4'hB};
        fork
            push(8'h4B, 1'b1);
            run_frame("t6");
        join
        check("t6 underrun", underrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
